// File: rtl/nios_system_mul_arbiter.sv
// Round-robin arbiter that shares one pipelined 32x32 multiply cell among NUM_REQ requesters.
// Latency: accept to registered response pulse is MUL_LATENCY+1 cycles, one accept per cycle.
// Backpressure: hold/flush/reset deassert every req_ready; responses cannot be stalled.
module nios_system_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 1,
    parameter int TAG_W       = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_src1,
    input  logic [32*NUM_REQ-1:0]  req_src2,
    input  logic                   hold,
    input  logic                   flush,
    output logic [31:0]            mul_src1,
    output logic [31:0]            mul_src2,
    input  logic [31:0]            mul_cell_result,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_data,
    output logic                   busy
);

    localparam logic [TAG_W:0]   NUM_REQ_W = (TAG_W+1)'(NUM_REQ);
    localparam logic [TAG_W-1:0] LAST_IDX  = TAG_W'(NUM_REQ - 1);

    logic [TAG_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   grant_vld;
    logic [TAG_W-1:0]       grant_idx;
    logic [TAG_W:0]         cand;

    logic [MUL_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [TAG_W-1:0]       pipe_tag_q [MUL_LATENCY];
    logic [TAG_W-1:0]       pipe_tag_d [MUL_LATENCY];

    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [31:0]            rsp_data_q, rsp_data_d;

    // Round-robin search starting at rr_ptr; the first valid requester wins unless blocked.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (TAG_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!grant_vld && req_valid[cand[TAG_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[TAG_W-1:0];
            end
        end
        if (hold || flush || reset) begin
            grant_vld = 1'b0;
        end
    end

    // One-hot ready and the operand mux toward the multiply cell; zeros when nothing is accepted.
    always_comb begin
        req_ready = '0;
        mul_src1  = '0;
        mul_src2  = '0;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
            mul_src1 = req_src1[32*grant_idx +: 32];
            mul_src2 = req_src2[32*grant_idx +: 32];
        end
    end

    // Next-state: pointer advance, tag shift (flush kills everything), response capture.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end

        pipe_vld_d    = '0;
        pipe_vld_d[0] = grant_vld;
        pipe_tag_d[0] = grant_idx;
        for (int i = 1; i < MUL_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_tag_d[i] = pipe_tag_q[i-1];
        end
        if (flush) begin
            pipe_vld_d = '0;
        end

        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (pipe_vld_q[MUL_LATENCY-1] && !flush) begin
            rsp_valid_d[pipe_tag_q[MUL_LATENCY-1]] = 1'b1;
            rsp_data_d = mul_cell_result;
        end
    end

    // State registers; reset drops all in-flight work immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            pipe_vld_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                pipe_tag_q[i] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            pipe_vld_q  <= pipe_vld_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                pipe_tag_q[i] <= pipe_tag_d[i];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (|pipe_vld_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_nios_system_mul_arbiter.sv
// Randomized bench for nios_system_mul_arbiter against a queue-based reference model.
// Latency: the model schedules each accepted op's response MUL_LATENCY+1 cycles out.
// Backpressure: hold/flush are driven randomly and in directed scenarios.
module tb_nios_system_mul_arbiter;

    localparam int N = 4;
    localparam int L = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_src1;
    logic [32*N-1:0]   req_src2;
    logic              hold;
    logic              flush;
    logic [31:0]       mul_src1;
    logic [31:0]       mul_src2;
    logic [31:0]       mul_cell_result;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_data;
    logic              busy;

    nios_system_mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src1(req_src1), .req_src2(req_src2),
        .hold(hold), .flush(flush),
        .mul_src1(mul_src1), .mul_src2(mul_src2),
        .mul_cell_result(mul_cell_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural multiply cell with L stages of latency.
    logic [31:0] cell_q [L];
    always_ff @(posedge clk) begin
        cell_q[0] <= mul_src1 * mul_src2;
        for (int i = 1; i < L; i++) cell_q[i] <= cell_q[i-1];
    end
    assign mul_cell_result = cell_q[L-1];

    // Reference model: pending responses with the cycle they must appear in.
    typedef struct {
        int          due;
        int          tag;
        logic [31:0] prod;
    } ent_t;

    ent_t        pend[$];
    int          m_ptr;
    int          cyc;
    logic [31:0] m_last_rd;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%08h exp=0x%08h", tag, cyc, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_src1[32*i +: 32] = a;
        req_src2[32*i +: 32] = b;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom);
    endtask

    task automatic model_reset();
        pend.delete();
        m_ptr     = 0;
        m_last_rd = '0;
    endtask

    // Called at posedge+1: drive one cycle, check at negedge, advance the model.
    task automatic run_cycle(input logic [N-1:0] v, input logic h, input logic f);
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rv;
        logic [31:0]  exp_rd, exp_s1, exp_s2;
        logic [63:0]  full;
        logic         exp_busy;
        int           gi;
        bit           acc;
        ent_t         e;
        req_valid = v;
        hold      = h;
        flush     = f;
        @(negedge clk);
        acc = 0;
        gi  = 0;
        if (!h && !f) begin
            for (int k = 0; k < N; k++) begin
                if (!acc && v[(m_ptr + k) % N]) begin
                    acc = 1;
                    gi  = (m_ptr + k) % N;
                end
            end
        end
        exp_ready = '0;
        exp_s1    = '0;
        exp_s2    = '0;
        if (acc) begin
            exp_ready[gi] = 1'b1;
            exp_s1 = req_src1[32*gi +: 32];
            exp_s2 = req_src2[32*gi +: 32];
        end
        exp_rv   = '0;
        exp_rd   = m_last_rd;
        exp_busy = 1'b0;
        foreach (pend[j]) begin
            if (pend[j].due == cyc) begin
                exp_rv[pend[j].tag] = 1'b1;
                exp_rd = pend[j].prod;
            end
            if (pend[j].due >= cyc) exp_busy = 1'b1;
        end
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("mul_src1", mul_src1, exp_s1);
        chk("mul_src2", mul_src2, exp_s2);
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv != '0) chk("rsp_data", rsp_data, exp_rd);
        chk("busy", 32'(busy), 32'(exp_busy));
        m_last_rd = exp_rd;
        for (int j = pend.size() - 1; j >= 0; j--) begin
            if (pend[j].due <= cyc || f) pend.delete(j);
        end
        if (acc) begin
            full   = 64'(exp_s1) * 64'(exp_s2);
            e.due  = cyc + L + 1;
            e.tag  = gi;
            e.prod = full[31:0];
            pend.push_back(e);
            m_ptr = (gi + 1) % N;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle('0, 1'b0, 1'b0);
    endtask

    logic [31:0] ov_a [4] = '{32'hFFFF_FFFF, 32'h0001_0000, 32'h0001_0003, 32'hFFFF_FFFF};
    logic [31:0] ov_b [4] = '{32'hFFFF_FFFF, 32'h0001_0000, 32'h0002_0005, 32'h0000_0002};
    logic [31:0] ov_e [4] = '{32'h0000_0001, 32'h0000_0000, 32'h000B_000F, 32'hFFFF_FFFE};

    initial begin
        reset     = 1'b1;
        req_valid = '1;
        hold      = 1'b0;
        flush     = 1'b0;
        rand_ops();
        cyc = 0;
        model_reset();
        #12;
        // Outputs while reset is held, with every requester asking.
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_src1", mul_src1, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        req_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single request 7*6 from requester 0.
        set_op(0, 32'd7, 32'd6);
        run_cycle(4'b0001, 1'b0, 1'b0);
        idle(1);
        chk("single_data", rsp_data, 32'd42);
        idle(1);

        // Full contention for 8 cycles.
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            run_cycle(4'b1111, 1'b0, 1'b0);
        end
        idle(3);

        // Wrap and overflow vectors.
        for (int i = 0; i < 4; i++) begin
            set_op(2, ov_a[i], ov_b[i]);
            run_cycle(4'b0100, 1'b0, 1'b0);
            idle(2);
            chk("ovf_data", rsp_data, ov_e[i]);
        end

        // Flush: accepts from 1 and 2, then flush, then everyone asks.
        rand_ops();
        run_cycle(4'b0010, 1'b0, 1'b0);
        run_cycle(4'b0100, 1'b0, 1'b0);
        run_cycle(4'b0000, 1'b0, 1'b1);
        idle(2);
        run_cycle(4'b1111, 1'b0, 1'b0);
        idle(3);

        // Hold: one op accepted, then hold for 5 cycles, then release.
        rand_ops();
        run_cycle(4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) run_cycle(4'b0011, 1'b1, 1'b0);
        run_cycle(4'b0011, 1'b0, 1'b0);
        idle(3);

        // Hold and flush together.
        run_cycle(4'b1000, 1'b0, 1'b0);
        run_cycle(4'b1111, 1'b1, 1'b1);
        idle(3);

        // Reset pulse between edges with two ops in flight.
        rand_ops();
        run_cycle(4'b0001, 1'b0, 1'b0);
        run_cycle(4'b0010, 1'b0, 1'b0);
        req_valid = '0;
        #1;
        chk("pre_rst_rsp", 32'(rsp_valid), 32'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("arst_rsp_data", rsp_data, 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        #1;
        reset = 1'b0;
        model_reset();
        cyc++;
        @(posedge clk);
        #1;
        idle(3);
        run_cycle(4'b1111, 1'b0, 1'b0);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            run_cycle(N'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0));
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout cycle=%0d", cyc);
        $fatal(1);
    end

endmodule
